result_requant_streamer: RTL

Output stage behind the 16x16 systolic-array tile engine. It captures one 16x16 tile of signed 32-bit accumulators on the engine's single-cycle result-valid pulse. Each element is requantized to signed 8-bit with a rounding arithmetic right shift, optional ReLU and saturation. The tile is then streamed out one 16-element row per cycle over a valid/ready handshake to the writeback buffer.

---
 rtl/npu_pkg.sv | 35 +++
 rtl/result_requant_streamer_requant_unit.sv | 34 +++
 rtl/result_requant_streamer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/npu_pkg.sv
// Shared constants, types and helpers for the tile-engine output path.
package npu_pkg;

    localparam int N     = 16;
    localparam int ACC_W = 32;
    localparam int OUT_W = 8;
    localparam int PTR_W = $clog2(N);

    // Saturation bounds expressed at the widened (ACC_W+1) working width.
    localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W + 2 - OUT_W){1'b1}}, {(OUT_W - 1){1'b0}}};

    typedef logic signed [N-1:0][N-1:0][ACC_W-1:0] acc_tile_t;
    typedef logic signed [N-1:0][ACC_W-1:0]        acc_row_t;
    typedef logic signed [N-1:0][OUT_W-1:0]        out_row_t;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } streamer_state_t;

    // Clamp a widened value into the signed output range.
    function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [ACC_W:0] v);
        logic signed [OUT_W-1:0] res;
        if (v > SAT_MAX) begin
            res = SAT_MAX[OUT_W-1:0];
        end else if (v < SAT_MIN) begin
            res = SAT_MIN[OUT_W-1:0];
        end else begin
            res = v[OUT_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/result_requant_streamer_requant_unit.sv
// Single-element requantizer: rounding arithmetic right shift, optional ReLU, saturation.
module requant_unit
    import npu_pkg::*;
(
    input  logic signed [ACC_W-1:0] i_acc,
    input  logic        [4:0]       i_shift,
    input  logic                    i_reluEn,
    output logic signed [OUT_W-1:0] o_q
);

    logic signed [ACC_W:0] ext_s;
    logic signed [ACC_W:0] half_s;
    logic signed [ACC_W:0] rnd_s;
    logic signed [ACC_W:0] relu_s;

    // Work one bit wider than the accumulator so adding the rounding half cannot overflow.
    always_comb begin
        ext_s  = {i_acc[ACC_W-1], i_acc};
        half_s = '0;
        if (i_shift != 5'd0) begin
            half_s = {{ACC_W{1'b0}}, 1'b1} << (i_shift - 5'd1);
            rnd_s  = (ext_s + half_s) >>> i_shift;
        end else begin
            rnd_s  = ext_s;
        end
        if (i_reluEn && rnd_s[ACC_W]) begin
            relu_s = '0;
        end else begin
            relu_s = rnd_s;
        end
        o_q = sat_out(relu_s);
    end

endmodule

// File: rtl/result_requant_streamer.sv
// Captures a 16x16 accumulator tile and streams it out one requantized row per handshake.
module result_requant_streamer
    import npu_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_arst_n,
    input  logic            i_validResult,
    input  acc_tile_t       i_c,
    input  logic [4:0]      i_shift,
    input  logic            i_reluEn,
    input  logic            i_clrErr,
    output out_row_t        o_rowData,
    output logic            o_rowValid,
    input  logic            i_rowReady,
    output logic [3:0]      o_rowIdx,
    output logic            o_rowLast,
    output logic            o_busy,
    output logic            o_dropErr
);

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(N - 1);

    streamer_state_t  state_r;
    streamer_state_t  state_next_s;
    logic [PTR_W-1:0] ptr_r;
    logic [PTR_W-1:0] ptr_next_s;
    acc_tile_t        buf_r;
    logic [4:0]       shift_r;
    logic             relu_r;
    logic             drop_err_r;
    logic             drop_err_next_s;

    logic             streaming_s;
    logic             hs_s;
    logic             last_hs_s;
    logic             capture_s;
    logic             drop_s;
    acc_row_t         row_s;
    out_row_t         q_s;

    // Handshake decode; a tile arriving on the final handshake is taken so the stream has no bubble.
    always_comb begin
        streaming_s = (state_r == STREAM);
        hs_s        = streaming_s & i_rowReady;
        last_hs_s   = hs_s & (ptr_r == LAST_PTR);
        capture_s   = i_validResult & (~streaming_s | last_hs_s);
        drop_s      = i_validResult & streaming_s & ~last_hs_s;
    end

    // Next-state, pointer and sticky error logic.
    always_comb begin
        state_next_s    = state_r;
        ptr_next_s      = ptr_r;
        drop_err_next_s = drop_err_r;
        case (state_r)
            IDLE: begin
                if (i_validResult) begin
                    state_next_s = STREAM;
                end else begin
                    state_next_s = IDLE;
                end
            end
            STREAM: begin
                if (last_hs_s && !i_validResult) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = STREAM;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
        if (capture_s) begin
            ptr_next_s = '0;
        end else if (hs_s) begin
            ptr_next_s = ptr_r + PTR_W'(1);
        end else begin
            ptr_next_s = ptr_r;
        end
        if (drop_s) begin
            drop_err_next_s = 1'b1;
        end else if (i_clrErr) begin
            drop_err_next_s = 1'b0;
        end else begin
            drop_err_next_s = drop_err_r;
        end
    end

    // Control registers: FSM state, row pointer and error flag.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_r    <= IDLE;
            ptr_r      <= '0;
            drop_err_r <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            ptr_r      <= ptr_next_s;
            drop_err_r <= drop_err_next_s;
        end
    end

    // Tile buffer and per-tile requant settings, loaded only on capture.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            buf_r   <= '0;
            shift_r <= 5'd0;
            relu_r  <= 1'b0;
        end else if (capture_s) begin
            buf_r   <= i_c;
            shift_r <= i_shift;
            relu_r  <= i_reluEn;
        end else begin
            buf_r   <= buf_r;
            shift_r <= shift_r;
            relu_r  <= relu_r;
        end
    end

    assign row_s = buf_r[ptr_r];

    for (genvar j = 0; j < N; j++) begin : g_rq
        requant_unit u_rq (
            .i_acc    (row_s[j]),
            .i_shift  (shift_r),
            .i_reluEn (relu_r),
            .o_q      (q_s[j])
        );
    end

    // Outputs depend on registers only, so they stay stable under backpressure.
    always_comb begin
        o_rowValid = streaming_s;
        o_busy     = streaming_s;
        o_rowIdx   = ptr_r;
        o_rowLast  = streaming_s & (ptr_r == LAST_PTR);
        o_dropErr  = drop_err_r;
        if (streaming_s) begin
            o_rowData = q_s;
        end else begin
            o_rowData = '0;
        end
    end

endmodule
